// File: rtl/regfile_32x64.sv
// 32 x WIDTH architectural register file: one synchronous write port, two combinational
// read ports built as 5-level 2:1 mux trees. X31 has no storage and always reads zero.
module regfile_32x64 #(
  parameter int WIDTH = 64,
  parameter int delay = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  // Gate delays are a property of the gate-level netlist; this description is zero-delay.
  if (delay < 0) begin : g_negative_delay
  end

  function automatic logic [WIDTH-1:0] mux2(input logic s,
                                            input logic [WIDTH-1:0] a0,
                                            input logic [WIDTH-1:0] a1);
    return s ? a1 : a0;
  endfunction

  logic [WIDTH-1:0] r_regs [0:30];
  logic [30:0]      w_we;
  logic [WIDTH-1:0] w_d    [0:30];
  logic [WIDTH-1:0] w_l0   [0:31];

  // Write decode and per-register load-enable mux; X31 has no decoder output at all.
  for (genvar i = 0; i < 31; i++) begin : g_store
    assign w_we[i] = RegWrite & (WriteRegister == 5'(i));
    assign w_d[i]  = mux2(w_we[i], r_regs[i], WriteData);

    always_ff @(posedge clk) begin
      if (reset) r_regs[i] <= '0;
      else       r_regs[i] <= w_d[i];
    end

    assign w_l0[i] = r_regs[i];
  end
  assign w_l0[31] = '0;

  logic [4:0]       w_sel [0:1];
  logic [WIDTH-1:0] w_rd  [0:1];
  assign w_sel[0] = ReadRegister1;
  assign w_sel[1] = ReadRegister2;

  // Select bit [0] drives the leaf level, bit [4] the root.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [WIDTH-1:0] w_l1 [0:15];
    logic [WIDTH-1:0] w_l2 [0:7];
    logic [WIDTH-1:0] w_l3 [0:3];
    logic [WIDTH-1:0] w_l4 [0:1];

    for (genvar j = 0; j < 16; j++) begin : g_lv1
      assign w_l1[j] = mux2(w_sel[p][0], w_l0[2*j], w_l0[2*j+1]);
    end
    for (genvar j = 0; j < 8; j++) begin : g_lv2
      assign w_l2[j] = mux2(w_sel[p][1], w_l1[2*j], w_l1[2*j+1]);
    end
    for (genvar j = 0; j < 4; j++) begin : g_lv3
      assign w_l3[j] = mux2(w_sel[p][2], w_l2[2*j], w_l2[2*j+1]);
    end
    for (genvar j = 0; j < 2; j++) begin : g_lv4
      assign w_l4[j] = mux2(w_sel[p][3], w_l3[2*j], w_l3[2*j+1]);
    end
    assign w_rd[p] = mux2(w_sel[p][4], w_l4[0], w_l4[1]);
  end

  assign ReadData1 = w_rd[0];
  assign ReadData2 = w_rd[1];

endmodule
